// File: rtl/sdram_ar_sched.sv
// sdram_ar_sched: SDRAM auto-refresh scheduler with postponed-refresh debt and burst catch-up
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   init_end   in   SDRAM initialisation complete (level); low clears FSM, debt and interval counter
//   ar_en      in   arbiter grant, held until ar_end
//   ar_req     out  refresh pending while idle
//   ar_urgent  out  debt has reached URG_TH
//   ar_end     out  one-cycle pulse at end of a refresh burst
//   ar_cmd     out  {cs_n,ras_n,cas_n,we_n}
//   ar_bank    out  bank address, fixed 2'b11
//   ar_addr    out  address, fixed 13'h1FFF (A10 selects precharge-all)
//   ar_debt    out  postponed-refresh count
//   ar_ovf     out  sticky: an interval tick was lost at saturated debt
module sdram_ar_sched #(
    parameter int T_REFI   = 780,
    parameter int T_RP     = 2,
    parameter int T_RFC    = 7,
    parameter int MAX_DEBT = 8,
    parameter int URG_TH   = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init_end,
    input  logic        ar_en,
    output logic        ar_req,
    output logic        ar_urgent,
    output logic        ar_end,
    output logic [3:0]  ar_cmd,
    output logic [1:0]  ar_bank,
    output logic [12:0] ar_addr,
    output logic [3:0]  ar_debt,
    output logic        ar_ovf
);
    localparam int CW = $clog2(T_REFI + 1);
    localparam int TW = $clog2((T_RP > T_RFC ? T_RP : T_RFC) + 1);
    localparam logic [3:0] C_NOP = 4'b0111;
    localparam logic [3:0] C_PRE = 4'b0010;
    localparam logic [3:0] C_AR  = 4'b0001;

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_TRP, S_AR, S_TRFC, S_END} state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [TW-1:0] r_tmr;
    logic [3:0]    r_debt;
    logic [3:0]    r_cmd;
    logic          r_end;
    logic          r_ovf;
    logic          w_tick;
    logic          w_issue;
    logic          w_lost;
    logic          w_inc;

    assign w_tick  = r_cnt == CW'(T_REFI - 1);
    assign w_issue = r_state == S_AR;
    // a tick at saturation is only lost if no refresh retires debt in the same cycle
    assign w_lost  = w_tick && r_debt == 4'(MAX_DEBT) && !w_issue;
    assign w_inc   = w_tick && !w_lost;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_tmr   <= '0;
            r_debt  <= '0;
            r_cmd   <= C_NOP;
            r_end   <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (!init_end) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_tmr   <= '0;
            r_debt  <= '0;
            r_cmd   <= C_NOP;
            r_end   <= 1'b0;
        end else begin
            r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
            if (w_lost)
                r_ovf <= 1'b1;
            if (w_inc && !w_issue)
                r_debt <= r_debt + 4'd1;
            else if (!w_inc && w_issue)
                r_debt <= r_debt - 4'd1;
            r_cmd <= C_NOP;
            r_end <= 1'b0;
            case (r_state)
                S_IDLE: if (ar_en && r_debt != 4'd0) begin
                    r_state <= S_PRE;
                    r_cmd   <= C_PRE;
                end
                S_PRE: begin
                    r_state <= S_TRP;
                    r_tmr   <= TW'(T_RP - 1);
                end
                S_TRP: if (r_tmr == '0) begin
                    r_state <= S_AR;
                    r_cmd   <= C_AR;
                end else
                    r_tmr <= r_tmr - 1'b1;
                S_AR: begin
                    r_state <= S_TRFC;
                    r_tmr   <= TW'(T_RFC - 1);
                end
                // r_debt here already reflects the decrement from the AR cycle
                S_TRFC: if (r_tmr != '0)
                    r_tmr <= r_tmr - 1'b1;
                else if (ar_en && r_debt != 4'd0) begin
                    r_state <= S_AR;
                    r_cmd   <= C_AR;
                end else begin
                    r_state <= S_END;
                    r_end   <= 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ar_req    = r_state == S_IDLE && r_debt != 4'd0;
    assign ar_urgent = r_debt >= 4'(URG_TH);
    assign ar_end    = r_end;
    assign ar_cmd    = r_cmd;
    assign ar_bank   = 2'b11;
    assign ar_addr   = 13'h1FFF;
    assign ar_debt   = r_debt;
    assign ar_ovf    = r_ovf;
endmodule

// File: tb/tb_sdram_ar_sched.sv
// tb_sdram_ar_sched: directed self-checking bench for sdram_ar_sched at default parameters
module tb_sdram_ar_sched;
    localparam int T_RP  = 2;
    localparam int T_RFC = 7;
    localparam logic [3:0] NOP = 4'b0111;
    localparam logic [3:0] PRE = 4'b0010;
    localparam logic [3:0] AR  = 4'b0001;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        init_end = 1'b0;
    logic        tie = 1'b0;
    logic        en_drv = 1'b0;
    logic        ar_en;
    logic        ar_req, ar_urgent, ar_end, ar_ovf;
    logic [3:0]  ar_cmd, ar_debt;
    logic [1:0]  ar_bank;
    logic [12:0] ar_addr;
    int          n_chk = 0;
    int          n_err = 0;
    int          cyc = 0;

    assign ar_en = tie ? ar_req : en_drv;

    sdram_ar_sched dut (
        .clk(clk), .rst_n(rst_n), .init_end(init_end), .ar_en(ar_en),
        .ar_req(ar_req), .ar_urgent(ar_urgent), .ar_end(ar_end), .ar_cmd(ar_cmd),
        .ar_bank(ar_bank), .ar_addr(ar_addr), .ar_debt(ar_debt), .ar_ovf(ar_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic wait_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_cmd"}, ar_cmd, NOP);
        chk({tag, "_bank"}, ar_bank, 2'b11);
        chk({tag, "_addr"}, ar_addr, 13'h1FFF);
        chk({tag, "_debt"}, ar_debt, 0);
        chk({tag, "_ovf"}, ar_ovf, 0);
        chk({tag, "_req"}, ar_req, 0);
        chk({tag, "_urg"}, ar_urgent, 0);
        chk({tag, "_end"}, ar_end, 0);
    endtask

    // called at the cycle PRECHARGE must be visible; returns at the ar_end cycle
    task automatic burst(input int k, input bit drop);
        chk("pre", ar_cmd, PRE);
        chk("pre_req", ar_req, 0);
        for (int j = 0; j < k; j++) begin
            repeat (j == 0 ? T_RP : T_RFC) begin
                step();
                chk("gap_nop", ar_cmd, NOP);
                chk("gap_end", ar_end, 0);
            end
            step();
            chk("ar", ar_cmd, AR);
        end
        repeat (T_RFC) begin
            step();
            if (drop) en_drv = 1'b0;
            chk("trfc_nop", ar_cmd, NOP);
            chk("trfc_end", ar_end, 0);
        end
        step();
        chk("end", ar_end, 1);
        chk("end_cmd", ar_cmd, NOP);
    endtask

    initial begin
        step();
        step();
        chk_reset("rst");
        rst_n = 1'b1;
        step();
        init_end = 1'b1;
        tie = 1'b1;
        cyc = 0;
        // first refresh with grant tied to request
        wait_to(779);
        chk("first_req_early", ar_req, 0);
        step();
        chk("first_req", ar_req, 1);
        chk("first_debt", ar_debt, 1);
        step();
        burst(1, 0);
        step();
        chk("first_debt0", ar_debt, 0);
        chk("first_idle_req", ar_req, 0);
        chk("first_end_pulse", ar_end, 0);
        tie = 1'b0;
        // six postponed refreshes, urgent threshold
        wait_to(5459);
        chk("debt5", ar_debt, 5);
        chk("urg_below", ar_urgent, 0);
        step();
        chk("debt6", ar_debt, 6);
        chk("urg_at", ar_urgent, 1);
        en_drv = 1'b1;
        step();
        burst(6, 0);
        step();
        chk("b6_debt0", ar_debt, 0);
        chk("b6_end_once", ar_end, 0);
        chk("b6_urg", ar_urgent, 0);
        en_drv = 1'b0;
        // saturation and overflow
        wait_to(12479);
        chk("sat_debt", ar_debt, 8);
        chk("sat_ovf0", ar_ovf, 0);
        step();
        chk("ovf_debt", ar_debt, 8);
        chk("ovf_set", ar_ovf, 1);
        en_drv = 1'b1;
        step();
        burst(8, 0);
        step();
        chk("b8_debt0", ar_debt, 0);
        chk("b8_ovf", ar_ovf, 1);
        en_drv = 1'b0;
        // grant dropped during first TRFC
        wait_to(14820);
        chk("d3", ar_debt, 3);
        en_drv = 1'b1;
        step();
        burst(1, 1);
        chk("drop_debt", ar_debt, 2);
        step();
        chk("drop_req", ar_req, 1);
        chk("drop_end", ar_end, 0);
        // tick coincident with AR issue at cycle 15600
        wait_to(15595);
        en_drv = 1'b1;
        step();
        burst(1, 1);
        chk("coinc_debt", ar_debt, 2);
        // init_end dropped mid-TRP
        step();
        chk("ie_req", ar_req, 1);
        en_drv = 1'b1;
        step();
        chk("ie_pre", ar_cmd, PRE);
        step();
        chk("ie_trp", ar_cmd, NOP);
        init_end = 1'b0;
        step();
        chk("ie_req0", ar_req, 0);
        chk("ie_debt0", ar_debt, 0);
        chk("ie_cmd", ar_cmd, NOP);
        chk("ie_end", ar_end, 0);
        en_drv = 1'b0;
        init_end = 1'b1;
        step();
        chk("ie_no_ar", ar_cmd, NOP);
        chk("ie_ovf_kept", ar_ovf, 1);
        wait_to(15611 + 779);
        chk("ie_cnt_early", ar_debt, 0);
        step();
        chk("ie_cnt_tick", ar_debt, 1);
        chk("ie_cnt_req", ar_req, 1);
        // asynchronous reset mid-TRFC
        en_drv = 1'b1;
        step();
        chk("rs_pre", ar_cmd, PRE);
        repeat (5) step();
        chk("rs_trfc", ar_cmd, NOP);
        en_drv = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk_reset("arst");
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/sdram_ar_sched.md
SDRAM_AR_SCHED -- requirements
Module: sdram_ar_sched

Interface
REQ-001 SHALL have parameter T_REFI, default 780, meaning clk cycles per refresh interval (7.8 us at 100 MHz).
REQ-002 SHALL have parameter T_RP, default 2, meaning NOP cycles after PRECHARGE.
REQ-003 SHALL have parameter T_RFC, default 7, meaning NOP cycles after AUTO REFRESH.
REQ-004 SHALL have parameter MAX_DEBT, default 8, meaning maximum postponed refreshes (1..15).
REQ-005 SHALL have parameter URG_TH, default 6, meaning debt level asserting ar_urgent (1..MAX_DEBT).
REQ-006 SHALL have clk  input  1  clock; all logic on rising edge.
REQ-007 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have init_end  input  1  SDRAM initialisation complete, level.
REQ-009 SHALL have ar_en  input  1  arbiter grant, level, held until ar_end.
REQ-010 SHALL have ar_req  output  1  refresh pending (debt>0, FSM in IDLE).
REQ-011 SHALL have ar_urgent  output  1  debt>=URG_TH; arbiter must grant at next opportunity.
REQ-012 SHALL have ar_end  output  1  one-cycle pulse, refresh burst finished.
REQ-013 SHALL have ar_cmd  output  4  {cs_n,ras_n,cas_n,we_n}.
REQ-014 SHALL have ar_bank  output  2  bank address, always 2'b11.
REQ-015 SHALL have ar_addr  output  13  address; 13'h1FFF (A10=1, precharge all) at all times.
REQ-016 SHALL have ar_debt  output  4  current postponed-refresh count.
REQ-017 SHALL have ar_ovf  output  1  sticky: interval tick lost because debt was saturated.

Function
REQ-018 Commands SHALL be NOP 4'b0111, PRECHARGE 4'b0010, AUTO REFRESH 4'b0001; ar_cmd=NOP in every cycle not listed below.
REQ-019 Interval counter SHALL count 0..T_REFI-1 while init_end=1, wrap to 0, and emit a one-cycle tick on wrap; held at 0 while init_end=0.
REQ-020 Tick SHALL increment ar_debt, saturating at MAX_DEBT; tick at saturation sets ar_ovf (cleared only by reset).
REQ-021 Each AUTO REFRESH issue SHALL decrement ar_debt; tick and issue in same cycle leave ar_debt unchanged.
REQ-022 FSM states: IDLE, PRE, TRP, AR, TRFC, END.
REQ-023 IDLE->PRE when ar_en=1 and ar_debt>0; ar_en with ar_debt=0 ignored.
REQ-024 PRE: one cycle, ar_cmd=PRECHARGE; ->TRP.
REQ-025 TRP: exactly T_RP cycles NOP; ->AR.
REQ-026 AR: one cycle, ar_cmd=AUTO REFRESH; ->TRFC.
REQ-027 TRFC: exactly T_RFC cycles NOP; then ->AR if ar_en=1 and post-decrement debt>0 (burst, no new PRECHARGE), else ->END.
REQ-028 END: one cycle, ar_end=1; ->IDLE.
REQ-029 ar_en deassert mid-burst SHALL NOT abort; current TRP/TRFC completes, then END.
REQ-030 ar_req SHALL be 0 in all states except IDLE; ar_urgent independent of FSM state.
REQ-031 init_end falling SHALL synchronously force FSM to IDLE, debt to 0, counter to 0.
REQ-032 Single refresh latency: grant sample to ar_end = 1+T_RP+1+T_RFC+1 cycles (12 at defaults); each extra burst refresh adds 1+T_RFC.

Reset
REQ-033 On rst_n=0: FSM IDLE, counter 0, ar_debt 0, ar_ovf 0, ar_req 0, ar_urgent 0, ar_end 0, ar_cmd NOP, ar_bank 2'b11, ar_addr 13'h1FFF.

Verification
REQ-034 init_end=1, ar_en tied to ar_req -> ar_req first at cycle 780 after init_end; PRE, 2 NOP, AR, 7 NOP, ar_end; debt back to 0.
REQ-035 ar_en held 0 for 6*780 cycles -> ar_debt=6, ar_urgent=1; grant -> one PRE then 6 AR spaced 8 cycles, single ar_end, debt 0.
REQ-036 ar_en held 0 for 9*780 cycles -> ar_debt=8, ar_ovf=1 and stays 1 after burst.
REQ-037 debt=3, grant, drop ar_en during first TRFC -> exactly one AR, ar_end, debt=2, ar_req reasserts next cycle.
REQ-038 tick coincident with AR issue -> ar_debt unchanged; init_end dropped mid-TRP -> IDLE, debt 0, cmd NOP next cycle.
REQ-039 rst_n asserted mid-TRFC -> all outputs at REQ-033 values immediately, asynchronously.
